usb_txn_ctrl: RTL and testbench
===============================

Name: usb_txn_ctrl

Overview:
Host-side transaction sequencer for the USB serial chain. It accepts one OUT or IN request from the host logic and drives bs_encoder with the TOKEN, DATA and handshake packets in order. It arms rc_dpdm/decode_nrzi to receive the handshake or data response, applies a response timeout, retries failed attempts and reports a single completion status.

Parameters:
TIMEOUT_CYCLES, 255, clk cycles allowed in a receive-wait state before rx_got_sync
MAX_RETRY, 3, retries after the first attempt before failing

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-high (1 = reset); name kept per codebase convention
txn_start  in  1  request pulse; sampled in IDLE only
txn_dir  in  1  0 = OUT, 1 = IN; latched with txn_start
txn_addr  in  7  device address; latched
txn_endp  in  4  endpoint; latched
txn_wdata  in  64  OUT payload; latched
txn_busy  out  1  transaction in progress
txn_done  out  1  one-cycle completion pulse
txn_ok  out  1  valid with txn_done: 1 = success
txn_rdata  out  64  IN payload; updated only on IN success
enc_pkt_type  out  2  00 none, 01 TOKEN, 10 DATA, 11 HSHAKE
enc_token  out  19  {PID8, addr7, endp4}
enc_data  out  72  {PID8, payload64}
enc_hshake  out  8  handshake PID byte
enc_free  in  1  encoder idle (free_inbound)
enc_sent  in  1  encoder finished packet (sent_pkt), one-cycle pulse
rx_receive_data  out  1  arm receiver for a data packet
rx_receive_hshake  out  1  arm receiver for a handshake
rx_abort  out  1  one-cycle receiver abort
rx_got_sync  in  1  SYNC detected
rx_eop_error  in  1  EOP error pulse
rx_done  in  1  packet fully received, one-cycle pulse
rx_pid  in  8  received PID byte; valid with rx_done
rx_rdata  in  64  received payload; valid with rx_done
rx_crc_ok  in  1  CRC16 check result; valid with rx_done

Behaviour:
- PID bytes are {~pid4, pid4}: OUT 8'hE1, IN 8'h69, DATA0 8'hC3, DATA1 8'h4B, ACK 8'hD2, NAK 8'h5A.
- Reset (rst_n = 1 at an edge) puts the FSM in IDLE, zeroes all outputs including txn_rdata, and clears the retry counter, timeout counter and toggle. Reset mid-transaction abandons it without txn_done.
- FSM states: IDLE, TOK, TOK_W, DAT, DAT_W, HS_RX, DIN_RX, ACK_TX, ACK_W, FIN.
- IDLE: on txn_start, latch the request and go to TOK. txn_busy = 1 from the next cycle until FIN.
- TOK, DAT, ACK_TX are issue states. enc_pkt_type is nonzero for exactly one cycle, namely the first cycle in the state with enc_free = 1; then go to the matching _W state. enc_token/enc_data/enc_hshake are held stable from issue until enc_sent.
- TOK_W on enc_sent: go to DAT if OUT, DIN_RX if IN.
- DAT_W on enc_sent: go to HS_RX.
- HS_RX holds rx_receive_hshake = 1; DIN_RX holds rx_receive_data = 1. Both are deasserted the cycle after leaving the state.
- Timeout counter clears on entry to HS_RX/DIN_RX, increments each cycle, and stops once rx_got_sync is seen. Reaching TIMEOUT_CYCLES fails the attempt.
- HS_RX results on rx_done: pid ACK = success; NAK or any other PID = fail attempt.
- DIN_RX results on rx_done:
  - pid DATA0/1 with rx_crc_ok = 1: latch txn_rdata, go to ACK_TX (enc_hshake = 8'hD2).
  - NAK: fail attempt.
  - crc bad or other PID: fail attempt, no handshake sent.
- rx_eop_error in any receive state fails the attempt.
- Failed attempt:
  - rx_abort pulses 1 cycle.
  - If retries < MAX_RETRY: increment, return to TOK.
  - Else: go to FIN with ok = 0.
- ACK_W on enc_sent: go to FIN with ok = 1.
- FIN, one cycle: txn_done = 1, txn_ok valid, txn_busy = 0 next cycle. Retry counter clears.
- txn_start while busy is ignored, not queued.
- Simultaneous rx_done and timeout terminal count: rx_done wins.

Optional Feature:
DATA_TOGGLE_EN
- Defined:
  - An OUT toggle bit selects DATA0/DATA1, flips on each OUT success, and is unchanged on failure or retry.
  - IN: expected PID alternates likewise. A received PID mismatching the expectation is ACKed but txn_rdata is not updated, and it is reported ok = 1.
  - Toggle clears on reset.
- Undefined: OUT always uses DATA0. IN accepts DATA0 or DATA1 without checking.

Test Plan:
- OUT addr 7'h05 endp 4'h1 wdata 64'h7FFE_0000_0000_0000, enc_free = 1, device returns ACK -> enc_token = {8'hE1, 7'h05, 4'h1}, then enc_data = {8'hC3, payload}, single pulse per packet, txn_done with ok = 1, rx_receive_hshake high only in HS_RX.
- OUT, device NAKs twice then ACKs -> three TOKEN+DATA pairs, two rx_abort pulses, ok = 1.
- IN, device returns DATA1 payload 64'hDEAD_BEEF_0123_4567 with crc ok -> ACK 8'hD2 sent, txn_rdata equals payload, ok = 1.
- IN with no rx_got_sync, TIMEOUT_CYCLES = 16, MAX_RETRY = 3 -> 4 token attempts, each abort 16 cycles after HS/DIN entry, ok = 0.
- rst_n asserted during DAT_W -> next cycle all outputs 0, no txn_done. A new txn_start after reset proceeds normally.
- With DATA_TOGGLE_EN, two successful OUTs -> PIDs 8'hC3 then 8'h4B. A NAKed retry between them repeats 8'h4B.

Source files
------------

// File: rtl/usb_txn_ctrl.sv
// usb_txn_ctrl: host-side USB transaction sequencer (TOKEN/DATA/handshake, response timeout, retry).
// Optional macro DATA_TOGGLE_EN enables DATA0/DATA1 sequencing for OUT and IN transfers.
module usb_txn_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        txn_start,
  input  logic        txn_dir,
  input  logic [6:0]  txn_addr,
  input  logic [3:0]  txn_endp,
  input  logic [63:0] txn_wdata,
  output logic        txn_busy,
  output logic        txn_done,
  output logic        txn_ok,
  output logic [63:0] txn_rdata,
  output logic [1:0]  enc_pkt_type,
  output logic [18:0] enc_token,
  output logic [71:0] enc_data,
  output logic [7:0]  enc_hshake,
  input  logic        enc_free,
  input  logic        enc_sent,
  output logic        rx_receive_data,
  output logic        rx_receive_hshake,
  output logic        rx_abort,
  input  logic        rx_got_sync,
  input  logic        rx_eop_error,
  input  logic        rx_done,
  input  logic [7:0]  rx_pid,
  input  logic [63:0] rx_rdata,
  input  logic        rx_crc_ok
);
  // state        | meaning
  // IDLE / FIN   | wait for request / one-cycle completion report
  // TOK,DAT,ACK_TX | issue packet once encoder is free; *_W waits for enc_sent
  // HS_RX/DIN_RX | receiver armed for handshake / IN data, timeout running
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_TOK, S_TOK_W, S_DAT, S_DAT_W, S_HS_RX, S_DIN_RX, S_ACK_TX, S_ACK_W, S_FIN
  } state_t;

  state_t        r_state;
  logic          r_dir;
  logic [6:0]    r_addr;
  logic [3:0]    r_endp;
  logic [63:0]   r_wdata;
  logic [RW-1:0] r_retry;
  logic [TW-1:0] r_to_cnt;
  logic          r_sync_seen;
  logic          r_busy;
  logic          r_done;
  logic          r_ok;
  logic [63:0]   r_rdata;
  logic [1:0]    r_pkt_type;
  logic [18:0]   r_token;
  logic [71:0]   r_enc_data;
  logic [7:0]    r_hshake;
  logic          r_rx_data;
  logic          r_rx_hs;
  logic          r_abort;

  logic       w_rx_state;
  logic       w_tmo;
  logic       w_is_data;
  logic       w_hs_ok;
  logic       w_din_ok;
  logic       w_fail;
  logic [7:0] w_out_pid;

`ifdef DATA_TOGGLE_EN
  logic r_tog_out;
  logic r_tog_in;
  assign w_out_pid = r_tog_out ? PID_DATA1 : PID_DATA0;
`else
  assign w_out_pid = PID_DATA0;
`endif

  assign w_rx_state = (r_state == S_HS_RX) || (r_state == S_DIN_RX);
  assign w_tmo      = !(r_sync_seen || rx_got_sync) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_is_data  = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);
  assign w_hs_ok    = (r_state == S_HS_RX) && rx_done && (rx_pid == PID_ACK);
  assign w_din_ok   = (r_state == S_DIN_RX) && rx_done && rx_crc_ok && w_is_data;
  // rx_done outranks a timeout terminal count in the same cycle
  assign w_fail     = w_rx_state &&
                      (rx_done ? !(w_hs_ok || w_din_ok) : (rx_eop_error || w_tmo));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b0;
      r_addr      <= '0;
      r_endp      <= '0;
      r_wdata     <= '0;
      r_retry     <= '0;
      r_to_cnt    <= '0;
      r_sync_seen <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ok        <= 1'b0;
      r_rdata     <= '0;
      r_pkt_type  <= 2'b00;
      r_token     <= '0;
      r_enc_data  <= '0;
      r_hshake    <= '0;
      r_rx_data   <= 1'b0;
      r_rx_hs     <= 1'b0;
      r_abort     <= 1'b0;
`ifdef DATA_TOGGLE_EN
      r_tog_out   <= 1'b0;
      r_tog_in    <= 1'b0;
`endif
    end else begin
      r_pkt_type <= 2'b00;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
      if (w_fail) begin
        r_abort   <= 1'b1;
        r_rx_data <= 1'b0;
        r_rx_hs   <= 1'b0;
        if (r_retry < RW'(MAX_RETRY)) begin
          r_retry <= r_retry + 1'b1;
          r_state <= S_TOK;
        end else begin
          r_done  <= 1'b1;
          r_ok    <= 1'b0;
          r_state <= S_FIN;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (txn_start) begin
              r_dir   <= txn_dir;
              r_addr  <= txn_addr;
              r_endp  <= txn_endp;
              r_wdata <= txn_wdata;
              r_busy  <= 1'b1;
              r_state <= S_TOK;
            end
          end
          S_TOK: begin
            if (enc_free) begin
              r_pkt_type <= 2'b01;
              r_token    <= {(r_dir ? PID_IN : PID_OUT), r_addr, r_endp};
              r_state    <= S_TOK_W;
            end
          end
          S_TOK_W: begin
            if (enc_sent) begin
              if (r_dir) begin
                r_rx_data   <= 1'b1;
                r_to_cnt    <= '0;
                r_sync_seen <= 1'b0;
                r_state     <= S_DIN_RX;
              end else begin
                r_state <= S_DAT;
              end
            end
          end
          S_DAT: begin
            if (enc_free) begin
              r_pkt_type <= 2'b10;
              r_enc_data <= {w_out_pid, r_wdata};
              r_state    <= S_DAT_W;
            end
          end
          S_DAT_W: begin
            if (enc_sent) begin
              r_rx_hs     <= 1'b1;
              r_to_cnt    <= '0;
              r_sync_seen <= 1'b0;
              r_state     <= S_HS_RX;
            end
          end
          S_HS_RX, S_DIN_RX: begin
            if (!(r_sync_seen || rx_got_sync)) r_to_cnt <= r_to_cnt + 1'b1;
            if (rx_got_sync) r_sync_seen <= 1'b1;
            if (w_hs_ok) begin
              r_rx_hs <= 1'b0;
              r_done  <= 1'b1;
              r_ok    <= 1'b1;
              r_state <= S_FIN;
`ifdef DATA_TOGGLE_EN
              r_tog_out <= ~r_tog_out;
`endif
            end else if (w_din_ok) begin
              r_rx_data <= 1'b0;
              r_hshake  <= PID_ACK;
              r_state   <= S_ACK_TX;
`ifdef DATA_TOGGLE_EN
              // a repeated packet (wrong toggle) is still ACKed but its payload dropped
              if (rx_pid == (r_tog_in ? PID_DATA1 : PID_DATA0)) begin
                r_rdata  <= rx_rdata;
                r_tog_in <= ~r_tog_in;
              end
`else
              r_rdata <= rx_rdata;
`endif
            end
          end
          S_ACK_TX: begin
            if (enc_free) begin
              r_pkt_type <= 2'b11;
              r_state    <= S_ACK_W;
            end
          end
          S_ACK_W: begin
            if (enc_sent) begin
              r_done  <= 1'b1;
              r_ok    <= 1'b1;
              r_state <= S_FIN;
            end
          end
          S_FIN: begin
            r_busy  <= 1'b0;
            r_retry <= '0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign txn_busy          = r_busy;
  assign txn_done          = r_done;
  assign txn_ok            = r_ok;
  assign txn_rdata         = r_rdata;
  assign enc_pkt_type      = r_pkt_type;
  assign enc_token         = r_token;
  assign enc_data          = r_enc_data;
  assign enc_hshake        = r_hshake;
  assign rx_receive_data   = r_rx_data;
  assign rx_receive_hshake = r_rx_hs;
  assign rx_abort          = r_abort;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// tb_usb_txn_ctrl: table-driven and randomized bench for usb_txn_ctrl with encoder/device models.
`timescale 1ns/1ps
module tb_usb_txn_ctrl;
  localparam int TMO = 16;
  localparam int MR  = 3;
  localparam logic [7:0] P_OUT = 8'hE1, P_IN = 8'h69, P_D0 = 8'hC3, P_D1 = 8'h4B;
  localparam logic [7:0] P_ACK = 8'hD2, P_NAK = 8'h5A;

  // kind: 0 silent (timeout), 1 normal packet, 2 EOP error, 3 packet completing on the timeout cycle
  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  pid;
    logic        crc;
    logic [63:0] data;
  } resp_t;

  typedef struct {
    logic        dir;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] wdata;
    resp_t [3:0] rs;
    logic        exp_ok;
    int          exp_ab;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic txn_start = 1'b0, txn_dir = 1'b0;
  logic [6:0] txn_addr = '0;
  logic [3:0] txn_endp = '0;
  logic [63:0] txn_wdata = '0;
  logic txn_busy, txn_done, txn_ok;
  logic [63:0] txn_rdata;
  logic [1:0] enc_pkt_type;
  logic [18:0] enc_token;
  logic [71:0] enc_data;
  logic [7:0] enc_hshake;
  logic enc_free = 1'b1, enc_sent = 1'b0;
  logic rx_receive_data, rx_receive_hshake, rx_abort;
  logic rx_got_sync = 1'b0, rx_eop_error = 1'b0, rx_done = 1'b0, rx_crc_ok = 1'b0;
  logic [7:0] rx_pid = '0;
  logic [63:0] rx_rdata = '0;

  always #5 clk = ~clk;

  usb_txn_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n),
    .txn_start(txn_start), .txn_dir(txn_dir), .txn_addr(txn_addr), .txn_endp(txn_endp),
    .txn_wdata(txn_wdata), .txn_busy(txn_busy), .txn_done(txn_done), .txn_ok(txn_ok),
    .txn_rdata(txn_rdata), .enc_pkt_type(enc_pkt_type), .enc_token(enc_token),
    .enc_data(enc_data), .enc_hshake(enc_hshake), .enc_free(enc_free), .enc_sent(enc_sent),
    .rx_receive_data(rx_receive_data), .rx_receive_hshake(rx_receive_hshake),
    .rx_abort(rx_abort), .rx_got_sync(rx_got_sync), .rx_eop_error(rx_eop_error),
    .rx_done(rx_done), .rx_pid(rx_pid), .rx_rdata(rx_rdata), .rx_crc_ok(rx_crc_ok)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic resp_t mk(input logic [1:0] k, input logic [7:0] p, input logic c,
                               input logic [63:0] d);
    resp_t r;
    r.kind = k; r.pid = p; r.crc = c; r.data = d;
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic [1:0]  mon_type[$];
  logic [71:0] mon_word[$];
  int lat_q[$];
  int n_abort = 0, n_done = 0, n_arm = 0, viol = 0, arm_cnt = 0;
  logic last_ok = 1'b0, prev_arm = 1'b0, prev_pkt = 1'b0, cur_dir = 1'b0, mon_arm;

  always @(negedge clk) begin
    mon_arm = rx_receive_hshake | rx_receive_data;
    if (mon_arm && !prev_arm) begin n_arm++; arm_cnt = 0; end
    else arm_cnt++;
    prev_arm = mon_arm;
    if (enc_pkt_type != 2'b00) begin
      if (prev_pkt) viol++;
      mon_type.push_back(enc_pkt_type);
      case (enc_pkt_type)
        2'b01:   mon_word.push_back(72'(enc_token));
        2'b10:   mon_word.push_back(enc_data);
        default: mon_word.push_back(72'(enc_hshake));
      endcase
    end
    prev_pkt = (enc_pkt_type != 2'b00);
    if (rx_abort) begin n_abort++; lat_q.push_back(arm_cnt); end
    if (txn_done) begin n_done++; last_ok = txn_ok; end
    if (rx_receive_hshake && rx_receive_data) viol++;
    if (rx_receive_hshake && cur_dir) viol++;
    if (rx_receive_data && !cur_dir) viol++;
  end

  // ---------------- encoder model ----------------
  always begin
    @(negedge clk);
    if (enc_pkt_type != 2'b00) begin
      repeat (2) @(negedge clk);
      enc_sent = 1'b1;
      @(negedge clk);
      enc_sent = 1'b0;
    end
  end

  // ---------------- device model ----------------
  resp_t resp_q[$];
  resp_t dev_r;
  logic dev_prev = 1'b0;

  always begin
    @(negedge clk);
    if ((rx_receive_hshake | rx_receive_data) && !dev_prev) begin
      if (resp_q.size() > 0) dev_r = resp_q.pop_front();
      else dev_r = mk(2'd0, 8'h00, 1'b0, 64'h0);
      case (dev_r.kind)
        2'd1: begin
          repeat (2) @(negedge clk);
          rx_got_sync = 1'b1;
          @(negedge clk);
          rx_got_sync = 1'b0;
          repeat (2) @(negedge clk);
          rx_pid = dev_r.pid; rx_crc_ok = dev_r.crc; rx_rdata = dev_r.data; rx_done = 1'b1;
          @(negedge clk);
          rx_done = 1'b0;
        end
        2'd2: begin
          repeat (3) @(negedge clk);
          rx_eop_error = 1'b1;
          @(negedge clk);
          rx_eop_error = 1'b0;
        end
        2'd3: begin
          repeat (TMO - 1) @(negedge clk);
          rx_pid = dev_r.pid; rx_crc_ok = dev_r.crc; rx_rdata = dev_r.data; rx_done = 1'b1;
          @(negedge clk);
          rx_done = 1'b0;
        end
        default: ;
      endcase
    end
    dev_prev = rx_receive_hshake | rx_receive_data;
  end

  // ---------------- reference model ----------------
  logic m_tog_out = 1'b0, m_tog_in = 1'b0;
  logic [63:0] m_rdata = '0;

  function automatic logic [7:0] out_pid();
`ifdef DATA_TOGGLE_EN
    return m_tog_out ? P_D1 : P_D0;
`else
    return P_D0;
`endif
  endfunction

  function automatic int lat_for(input logic [1:0] k);
    case (k)
      2'd1:    return 6;
      2'd2:    return 4;
      default: return TMO;
    endcase
  endfunction

  task automatic run_txn(input logic dir, input logic [6:0] addr, input logic [3:0] endp,
                         input logic [63:0] wdata, input resp_t [3:0] rs, input bit stall,
                         input bit extra, output logic ok_o, output int ab_o);
    logic [1:0]  e_type[$];
    logic [71:0] e_word[$];
    int e_lat[$];
    logic e_ok;
    int e_ab, e_arm, wc;
    e_ok = 1'b0; e_ab = 0; e_arm = 0;
    for (int a = 0; a <= MR; a++) begin
      e_arm++;
      e_type.push_back(2'b01);
      e_word.push_back(72'({(dir ? P_IN : P_OUT), addr, endp}));
      if (!dir) begin
        e_type.push_back(2'b10);
        e_word.push_back({out_pid(), wdata});
        if (rs[a].kind inside {2'd1, 2'd3} && rs[a].pid == P_ACK) begin
          e_ok = 1'b1; m_tog_out = ~m_tog_out;
          break;
        end
      end else if (rs[a].kind inside {2'd1, 2'd3} && rs[a].crc && rs[a].pid inside {P_D0, P_D1}) begin
        e_type.push_back(2'b11);
        e_word.push_back(72'(P_ACK));
        e_ok = 1'b1;
`ifdef DATA_TOGGLE_EN
        if (rs[a].pid == (m_tog_in ? P_D1 : P_D0)) begin
          m_rdata = rs[a].data; m_tog_in = ~m_tog_in;
        end
`else
        m_rdata = rs[a].data;
`endif
        break;
      end
      e_ab++;
      e_lat.push_back(lat_for(rs[a].kind));
    end

    mon_type.delete(); mon_word.delete(); lat_q.delete();
    n_abort = 0; n_done = 0; n_arm = 0; viol = 0;
    resp_q.delete();
    for (int a = 0; a < 4; a++) resp_q.push_back(rs[a]);
    cur_dir = dir;
    if (stall) enc_free = 1'b0;
    txn_dir = dir; txn_addr = addr; txn_endp = endp; txn_wdata = wdata; txn_start = 1'b1;
    @(negedge clk);
    txn_start = 1'b0;
    check("busy_on", txn_busy, 1'b1);
    if (stall) begin
      repeat (6) @(negedge clk);
      check("stall_hold", {txn_busy, enc_pkt_type, 32'(mon_type.size())}, {1'b1, 2'b00, 32'd0});
      enc_free = 1'b1;
    end
    if (extra) begin
      @(negedge clk);
      txn_dir = ~dir; txn_addr = ~addr; txn_start = 1'b1;
      @(negedge clk);
      txn_start = 1'b0;
    end
    wc = 0;
    while (n_done == 0 && wc < 3000) begin @(negedge clk); wc++; end
    check("done_seen", n_done != 0, 1'b1);
    repeat (3) @(negedge clk);
    check("done_cnt", n_done, 1);
    check("busy_off", txn_busy, 1'b0);
    check("ok", last_ok, e_ok);
    check("aborts", n_abort, e_ab);
    check("arms", n_arm, e_arm);
    check("npkt", mon_type.size(), e_type.size());
    for (int i = 0; i < e_type.size() && i < mon_type.size(); i++) begin
      check($sformatf("pkt%0d_type", i), mon_type[i], e_type[i]);
      check($sformatf("pkt%0d_word", i), mon_word[i], e_word[i]);
    end
    check("nlat", lat_q.size(), e_lat.size());
    for (int i = 0; i < e_lat.size() && i < lat_q.size(); i++)
      check($sformatf("abort%0d_latency", i), lat_q[i], e_lat[i]);
    check("rdata", txn_rdata, m_rdata);
    check("protocol", viol, 0);
    resp_q.delete();
    ok_o = last_ok;
    ab_o = n_abort;
  endtask

  function automatic vec_t mkv(input logic d, input logic [6:0] a, input logic [3:0] e,
                               input logic [63:0] w, input resp_t r0, input resp_t r1,
                               input resp_t r2, input resp_t r3, input logic ok, input int ab);
    vec_t v;
    v.dir = d; v.addr = a; v.endp = e; v.wdata = w;
    v.rs[0] = r0; v.rs[1] = r1; v.rs[2] = r2; v.rs[3] = r3;
    v.exp_ok = ok; v.exp_ab = ab;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  vec_t vt[11];
  resp_t R_TO, R_ACK, R_NAK, R_EOP, R_LACK, rr[4];
  resp_t [3:0] rsr;
  logic got_ok;
  int got_ab, wait_cyc;
  logic [7:0] pids[5];

  initial begin
    R_TO   = mk(2'd0, 8'h00, 1'b0, 64'h0);
    R_ACK  = mk(2'd1, P_ACK, 1'b1, 64'h0);
    R_NAK  = mk(2'd1, P_NAK, 1'b1, 64'h0);
    R_EOP  = mk(2'd2, 8'h00, 1'b0, 64'h0);
    R_LACK = mk(2'd3, P_ACK, 1'b1, 64'h0);
    pids[0] = P_ACK; pids[1] = P_NAK; pids[2] = P_D0; pids[3] = P_D1; pids[4] = 8'hA5;

    repeat (3) @(negedge clk);
    check("rst_ctl", {txn_busy, txn_done, txn_ok, enc_pkt_type, rx_receive_data,
                      rx_receive_hshake, rx_abort}, '0);
    check("rst_rdata", txn_rdata, '0);
    check("rst_enc", {enc_token, enc_hshake}, '0);
    check("rst_data", enc_data, '0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    vt[0]  = mkv(1'b0, 7'h05, 4'h1, 64'h7FFE_0000_0000_0000, R_ACK, R_TO, R_TO, R_TO, 1'b1, 0);
    vt[1]  = mkv(1'b0, 7'h22, 4'h3, 64'hA5A5_5A5A_0F0F_F0F0, R_NAK, R_NAK, R_ACK, R_TO, 1'b1, 2);
    vt[2]  = mkv(1'b1, 7'h05, 4'h1, 64'h0,
                 mk(2'd1, P_D1, 1'b1, 64'hDEAD_BEEF_0123_4567), R_TO, R_TO, R_TO, 1'b1, 0);
    vt[3]  = mkv(1'b1, 7'h0A, 4'h2, 64'h0, R_TO, R_TO, R_TO, R_TO, 1'b0, 4);
    vt[4]  = mkv(1'b0, 7'h7F, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, R_EOP, R_ACK, R_TO, R_TO, 1'b1, 1);
    vt[5]  = mkv(1'b1, 7'h01, 4'h0, 64'h0, R_NAK, mk(2'd1, P_D0, 1'b0, 64'h1234),
                 mk(2'd1, 8'hA5, 1'b1, 64'h5678), mk(2'd1, P_D0, 1'b1, 64'h0123_4567_89AB_CDEF),
                 1'b1, 3);
    vt[6]  = mkv(1'b0, 7'h10, 4'h4, 64'h0000_0000_0000_0001, R_LACK, R_TO, R_TO, R_TO, 1'b1, 0);
    vt[7]  = mkv(1'b0, 7'h11, 4'h5, 64'h8000_0000_0000_0000, R_NAK, R_NAK, R_NAK, R_NAK, 1'b0, 4);
    vt[8]  = mkv(1'b1, 7'h33, 4'h6, 64'h0, R_EOP, R_TO,
                 mk(2'd1, P_D0, 1'b1, 64'h55AA_55AA_1234_5678), R_TO, 1'b1, 2);
    vt[9]  = mkv(1'b0, 7'h44, 4'h7, 64'h0BAD_F00D_0000_0001, R_ACK, R_TO, R_TO, R_TO, 1'b1, 0);
    vt[10] = mkv(1'b0, 7'h45, 4'h8, 64'h0BAD_F00D_0000_0002, R_NAK, R_ACK, R_TO, R_TO, 1'b1, 1);

    for (int i = 0; i < 11; i++) begin
      run_txn(vt[i].dir, vt[i].addr, vt[i].endp, vt[i].wdata, vt[i].rs, (i == 1), (i == 2),
              got_ok, got_ab);
      check($sformatf("vec%0d_ok", i), got_ok, vt[i].exp_ok);
      check($sformatf("vec%0d_aborts", i), got_ab, vt[i].exp_ab);
    end

    // reset while waiting for the DATA packet to leave the encoder
    mon_type.delete(); mon_word.delete(); n_done = 0;
    resp_q.delete(); resp_q.push_back(R_ACK);
    cur_dir = 1'b0;
    txn_dir = 1'b0; txn_addr = 7'h2B; txn_endp = 4'h9; txn_wdata = 64'h1111_2222_3333_4444;
    txn_start = 1'b1;
    @(negedge clk);
    txn_start = 1'b0;
    wait_cyc = 0;
    while (mon_type.size() < 2 && wait_cyc < 200) begin @(negedge clk); wait_cyc++; end
    check("rst_reach_data", mon_type.size() >= 2, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    check("midrst_ctl", {txn_busy, txn_done, txn_ok, enc_pkt_type, rx_receive_data,
                         rx_receive_hshake, rx_abort}, '0);
    check("midrst_rdata", txn_rdata, '0);
    check("midrst_enc", {enc_token, enc_hshake}, '0);
    check("midrst_data", enc_data, '0);
    repeat (20) @(negedge clk);
    check("midrst_no_done", n_done, 0);
    check("midrst_idle", txn_busy, 1'b0);
    resp_q.delete();
    m_rdata = '0; m_tog_out = 1'b0; m_tog_in = 1'b0;

    run_txn(vt[0].dir, vt[0].addr, vt[0].endp, vt[0].wdata, vt[0].rs, 1'b0, 1'b0, got_ok, got_ab);
    check("post_rst_ok", got_ok, 1'b1);

    for (int n = 0; n < 25; n++) begin
      for (int a = 0; a < 4; a++) begin
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel == 0) rr[a] = R_TO;
        else if (sel == 1) rr[a] = R_EOP;
        else if (sel == 9) rr[a] = mk(2'd3, pids[$urandom_range(0, 4)], 1'b1, {$urandom, $urandom});
        else rr[a] = mk(2'd1, pids[$urandom_range(0, 4)], ($urandom_range(0, 3) != 0),
                        {$urandom, $urandom});
        rsr[a] = rr[a];
      end
      run_txn(1'($urandom_range(0, 1)), 7'($urandom), 4'($urandom), {$urandom, $urandom},
              rsr, 1'b0, 1'b0, got_ok, got_ab);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
